// File: rtl/lc3_pipeline_controller.sv
// LC3 pipeline sequencer: per-stage enables, branch resolution,
// load/store memory stalls and ALU result bypass selection.
module lc3_pipeline_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic [1:0]  mem_state
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [2:0] {
    S_RUN, S_BR1, S_BR2, S_MEM1, S_MEM2, S_LDWB
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_vd, r_ve, r_vw;
  logic   w_vd_nxt, w_ve_nxt, w_vw_nxt;

  logic [3:0] w_op_d, w_op_e;
  logic       w_alu_e, w_regwr_e, w_memop_e, w_load_e, w_indirect_e;
  logic       w_ctrl_d, w_src1_d, w_src2_d, w_byp_base;

  assign w_op_d       = IR[15:12];
  assign w_op_e       = IR_Exec[15:12];
  assign w_alu_e      = (w_op_e == OP_ADD) || (w_op_e == OP_AND) || (w_op_e == OP_NOT);
  assign w_regwr_e    = w_alu_e || (w_op_e == OP_LEA);
  assign w_load_e     = (w_op_e == OP_LD) || (w_op_e == OP_LDR) || (w_op_e == OP_LDI);
  assign w_memop_e    = w_load_e || (w_op_e == OP_ST) || (w_op_e == OP_STR) ||
                        (w_op_e == OP_STI);
  assign w_indirect_e = (w_op_e == OP_LDI) || (w_op_e == OP_STI);
  assign w_ctrl_d     = (w_op_d == OP_BR) || (w_op_d == OP_JMP);
  assign w_src1_d     = (w_op_d == OP_ADD) || (w_op_d == OP_AND) || (w_op_d == OP_NOT) ||
                        (w_op_d == OP_ST)  || (w_op_d == OP_STR) || (w_op_d == OP_LDR);
  assign w_src2_d     = ((w_op_d == OP_ADD) || (w_op_d == OP_AND)) && !IR[5];
  assign w_byp_base   = r_vw && w_alu_e && r_ve;

  // State and valid-bit registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_vd    <= 1'b0;
      r_ve    <= 1'b0;
      r_vw    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vd    <= w_vd_nxt;
      r_ve    <= w_ve_nxt;
      r_vw    <= w_vw_nxt;
    end
  end

  // Next-state, valid-bit advance and output decode; reset forces idle outputs
  always_comb begin
    enable_fetch     = 1'b0;
    enable_updatePC  = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    br_taken         = 1'b0;
    bypass_alu_1     = 1'b0;
    bypass_alu_2     = 1'b0;
    mem_state        = 2'd3;
    w_state_nxt      = r_state;
    w_vd_nxt         = r_vd;
    w_ve_nxt         = r_ve;
    w_vw_nxt         = r_vw;
    if (reset) begin
      case (r_state)
        S_RUN: begin
          bypass_alu_1 = w_byp_base && w_src1_d && (IR_Exec[11:9] == IR[8:6]);
          bypass_alu_2 = w_byp_base && w_src2_d && (IR_Exec[11:9] == IR[2:0]);
          if (r_vw && w_memop_e) begin
            w_state_nxt = S_MEM1;
          end else if (r_ve && w_ctrl_d) begin
            // Branch still executes this cycle; younger fetch/decode are squashed
            enable_execute   = 1'b1;
            enable_writeback = r_vw && w_regwr_e;
            w_state_nxt      = S_BR1;
            w_vd_nxt         = 1'b0;
          end else if (complete_instr) begin
            enable_fetch     = 1'b1;
            enable_updatePC  = 1'b1;
            enable_decode    = r_vd;
            enable_execute   = r_ve;
            enable_writeback = r_vw && w_regwr_e;
            w_vd_nxt         = 1'b1;
            w_ve_nxt         = r_vd;
            w_vw_nxt         = r_ve;
          end
        end
        S_BR1: w_state_nxt = S_BR2;
        S_BR2: begin
          enable_updatePC = 1'b1;
          br_taken        = (w_op_e == OP_JMP) ? 1'b1 : |(NZP & psr);
          w_state_nxt     = S_RUN;
          w_vd_nxt        = 1'b0;
          w_ve_nxt        = 1'b0;
          w_vw_nxt        = 1'b0;
        end
        S_MEM1: begin
          mem_state = w_indirect_e ? 2'd1 : (w_load_e ? 2'd0 : 2'd2);
          if (complete_data) begin
            if (w_indirect_e) begin
              w_state_nxt = S_MEM2;
            end else if (w_load_e) begin
              w_state_nxt = S_LDWB;
            end else begin
              w_state_nxt = S_RUN;
              w_vw_nxt    = 1'b0;
            end
          end
        end
        S_MEM2: begin
          mem_state = w_load_e ? 2'd0 : 2'd2;
          if (complete_data) begin
            if (w_load_e) begin
              w_state_nxt = S_LDWB;
            end else begin
              w_state_nxt = S_RUN;
              w_vw_nxt    = 1'b0;
            end
          end
        end
        S_LDWB: begin
          enable_writeback = 1'b1;
          w_state_nxt      = S_RUN;
          w_vw_nxt         = 1'b0;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

endmodule
